// File: rtl/mem_image_loader_pkg.sv
// Shared definitions for the memory image loader: FSM states, frame markers, TGT byte layout.
package mem_image_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // TGT byte layout: bit 0 picks the memory, bit 7 flags the last frame, the rest are reserved.
  localparam int unsigned TGT_SEL_BIT   = 0;
  localparam int unsigned TGT_LAST_BIT  = 7;
  localparam logic [7:0]  TGT_RSVD_MASK = 8'h7E;

  typedef enum logic [2:0] {
    StIdle,
    StTgt,
    StAddr,
    StCnt,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  // A TGT byte is acceptable only when all reserved bits are clear.
  function automatic logic tgt_valid(logic [7:0] tgt);
    return (tgt & TGT_RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/mem_image_loader_if.sv
// Byte stream input plus memory word-write port of the image loader.
// master: the loader side (accepts bytes, drives the memory port); slave: link/memory side.
interface mem_image_loader_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_sel,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_sel,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );

endinterface

// File: rtl/mem_image_loader_word_asm.sv
// Big-endian word assembler: shifts data bytes in MSB first and flags the 4th byte of each word.
module mem_image_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;

  // The word completes on the transfer of its 4th byte; the caller registers it.
  assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_data_i};

  // Next-state for byte position and the three leading bytes of the word.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clr_i) begin
      byte_cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], byte_data_i};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/mem_image_loader.sv
// Memory image loader: parses framed byte stream, writes big-endian words to instr/data memory,
// keeps the core in reset until the last frame commits with a good checksum.
module mem_image_loader
  import mem_image_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_image_loader_if.master  bus,
  output logic                core_rst,
  output logic                done,
  output logic                err
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              in_ready;
  logic              xfer;
  logic [7:0]        in_byte;
  logic              word_valid;
  logic [31:0]       word;

  assign in_ready = (state_q != StDone);
  assign xfer     = bus.in_valid && in_ready;
  assign in_byte  = bus.in_data;

  assign bus.in_ready  = in_ready;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

  // Core release and sticky status follow directly from the terminal states.
  assign done     = (state_q == StDone);
  assign core_rst = (state_q != StDone);
  assign err      = (state_q == StErr);

  // Assembler only sees payload bytes; its position is cleared outside the payload.
  mem_image_loader_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != StData),
    .byte_valid_i (xfer && (state_q == StData)),
    .byte_data_i  (in_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Frame parser: next state, header fields, running checksum and write strobe.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (xfer && (in_byte == SYNC_BYTE)) begin
          state_d = StTgt;
          csum_d  = 8'h00;
        end
      end
      StTgt: begin
        if (xfer) begin
          csum_d       = csum_q ^ in_byte;
          sel_d        = in_byte[TGT_SEL_BIT];
          last_d       = in_byte[TGT_LAST_BIT];
          idx_d        = 2'd0;
          words_left_d = '0;
          state_d      = tgt_valid(in_byte) ? StAddr : StErr;
        end
      end
      StAddr: begin
        if (xfer) begin
          csum_d = csum_q ^ in_byte;
          addr_d = {addr_q[ADDR_W-9:0], in_byte};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = (in_byte[1:0] != 2'b00) ? StErr : StCnt;
          end
        end
      end
      StCnt: begin
        if (xfer) begin
          csum_d       = csum_q ^ in_byte;
          words_left_d = {words_left_q[CNT_W-9:0], in_byte};
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_d   = 2'd0;
            state_d = (words_left_d == '0) ? StCsum : StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q ^ in_byte;
        end
        if (word_valid) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q;
          mem_wdata_d  = word;
          addr_d       = addr_q + ADDR_W'(4);
          words_left_d = words_left_q - CNT_W'(1);
          if (words_left_q == CNT_W'(1)) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          if (in_byte != csum_q) begin
            state_d = StErr;
          end else begin
            state_d = last_q ? StDone : StIdle;
          end
        end
      end
      StDone, StErr: begin
        // Terminal until reset.
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= 1'b0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      words_left_q <= '0;
      idx_q        <= 2'd0;
      csum_q       <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader with a frame-level model of expected writes and status.
module tb_mem_image_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, done, err;

  always #5 clk = ~clk;

  mem_image_loader_if #(.ADDR_W(32)) bus ();

  mem_image_loader #(
    .SYNC_BYTE (8'hA5),
    .CNT_W     (16),
    .ADDR_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];   // writes the model says must appear, in order
  logic [7:0]  sq[$];      // byte stream still to be sent
  logic [31:0] wq[$];      // payload words of the frame being built
  int          m_state;    // model status: 0 loading, 1 done, 2 error
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock; sample #1 after the edge and check any write against the model.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got sel %0b addr %h data %h, required no write",
                 bus.mem_sel, bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_sel", 64'(bus.mem_sel), 64'(e.sel));
        check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
    check("core_rst_vs_done", 64'(core_rst), 64'(!done));
    check("in_ready_vs_done", 64'(bus.in_ready), 64'(!done));
  endtask

  // Build one frame into the stream and apply the frame-level rules to the model.
  task automatic model_frame(input logic [7:0] tgt, input logic [31:0] addr, input int n,
                             input logic [7:0] flip);
    logic [7:0]  fr[$];
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t         e;
    fr.push_back(tgt);
    for (int i = 3; i >= 0; i--) fr.push_back(addr[8*i +: 8]);
    fr.push_back(n[15:8]);
    fr.push_back(n[7:0]);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      for (int j = 3; j >= 0; j--) fr.push_back(w[8*j +: 8]);
    end
    cs = 8'h00;
    foreach (fr[i]) cs = cs ^ fr[i];
    sq.push_back(8'hA5);
    foreach (fr[i]) sq.push_back(fr[i]);
    sq.push_back(cs ^ flip);
    if (m_state == 0) begin
      if ((tgt & 8'h7E) != 8'h00 || addr[1:0] != 2'b00) begin
        m_state = 2;
      end else begin
        for (int i = 0; i < n; i++) begin
          e.sel  = tgt[0];
          e.addr = addr + 32'(4 * i);
          e.data = wq[i];
          exp_q.push_back(e);
        end
        if (flip != 8'h00) m_state = 2;
        else if (tgt[7]) m_state = 1;
      end
    end
    wq.delete();
  endtask

  task automatic send(input int k, input bit gaps);
    for (int i = 0; i < k; i++) begin
      if (sq.size() == 0) break;
      bus.in_valid = 1'b1;
      bus.in_data  = sq.pop_front();
      tick();
      bus.in_valid = 1'b0;
      if (gaps) tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_all(input bit gaps);
    send(sq.size(), gaps);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"}, 64'(done), 64'(m_state == 1));
    check({tag, "_err"}, 64'(err), 64'(m_state == 2));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(m_state != 1));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_sel"}, 64'(bus.mem_sel), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    sq.delete();
    wq.delete();
    m_state = 0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    m_state      = 0;

    // 1: single last frame, exact write latency and release
    do_reset();
    wq.push_back(32'hDEADBEEF);
    model_frame(8'h80, 32'h0000_2000, 1, 8'h00);
    check("t1_csum_byte", 64'(sq[sq.size()-1]), 64'h83);
    send(11, 1'b0);
    check("t1_no_early_we", 64'(bus.mem_we), 64'd0);
    send(1, 1'b0);
    check("t1_we_latency", 64'(bus.mem_we), 64'd1);
    check("t1_addr_lit", 64'(bus.mem_addr), 64'h2000);
    check("t1_data_lit", 64'(bus.mem_wdata), 64'hDEADBEEF);
    send(1, 1'b0);
    check("t1_done_lit", 64'(done), 64'd1);
    check("t1_core_rst_lit", 64'(core_rst), 64'd0);
    check("t1_in_ready_lit", 64'(bus.in_ready), 64'd0);
    check_status("t1");

    // 2: two frames, done only after the second checksum
    do_reset();
    wq.push_back(32'h1111_1111);
    wq.push_back(32'h2222_2222);
    model_frame(8'h00, 32'h0, 2, 8'h00);
    send_all(1'b0);
    check_status("t2a");
    wq.push_back(32'h3333_3333);
    model_frame(8'h81, 32'h0000_2000, 1, 8'h00);
    send_all(1'b0);
    check_status("t2b");
    check("t2_sel_lit", 64'(bus.mem_sel), 64'd1);

    // 3: bad checksum on last frame, later frames ignored
    do_reset();
    wq.push_back(32'hCAFE_F00D);
    model_frame(8'h80, 32'h0000_0100, 1, 8'h01);
    send_all(1'b0);
    check_status("t3a");
    check("t3_err_lit", 64'(err), 64'd1);
    wq.push_back(32'h1234_5678);
    model_frame(8'h80, 32'h0000_0200, 1, 8'h00);
    send_all(1'b0);
    check_status("t3b");

    // 4: misaligned address flagged at the 4th address byte
    do_reset();
    wq.push_back(32'hAABB_CCDD);
    model_frame(8'h80, 32'h0000_2002, 1, 8'h00);
    send(5, 1'b0);
    check("t4_err_before", 64'(err), 64'd0);
    send(1, 1'b0);
    check("t4_err_at_addr", 64'(err), 64'd1);
    send_all(1'b0);
    check_status("t4");

    // 5: garbage before SYNC with in_valid toggling
    do_reset();
    sq.push_back(8'h00);
    sq.push_back(8'hFF);
    sq.push_back(8'h12);
    wq.push_back(32'hDEADBEEF);
    model_frame(8'h80, 32'h0000_2000, 1, 8'h00);
    send_all(1'b1);
    check_status("t5");

    // 6: reset mid-word aborts the frame, then a fresh frame loads
    do_reset();
    wq.push_back(32'h0102_0304);
    wq.push_back(32'h0506_0708);
    model_frame(8'h80, 32'h0000_0040, 2, 8'h00);
    send(10, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    sq.delete();
    m_state = 0;
    tick();
    check_reset_vals("t6_abort");
    rst = 1'b0;
    tick();
    wq.push_back(32'hDEADBEEF);
    model_frame(8'h80, 32'h0000_2000, 1, 8'h00);
    send_all(1'b0);
    check_status("t6");

    // 7: empty last frame, then address wrap at the top of memory
    do_reset();
    model_frame(8'h80, 32'h0000_1000, 0, 8'h00);
    send_all(1'b0);
    check_status("t7a");
    do_reset();
    wq.push_back(32'hA1A2_A3A4);
    wq.push_back(32'hB1B2_B3B4);
    model_frame(8'h81, 32'hFFFF_FFFC, 2, 8'h00);
    send_all(1'b0);
    check_status("t7b");
    check("t7_wrap_addr_lit", 64'(bus.mem_addr), 64'h0);

    // 8: reserved TGT bit set
    do_reset();
    wq.push_back(32'h5555_AAAA);
    model_frame(8'h82, 32'h0, 1, 8'h00);
    send_all(1'b0);
    check_status("t8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
